// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: architectural HI/LO plus a fixed-latency
// mult/multu/div/divu engine with a registered busy for the hazard unit.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MDU_A,
  input  logic [31:0] MDU_B,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MFHI  = 4'b0101;
  localparam logic [3:0] OP_MFLO  = 4'b0110;
  localparam logic [3:0] OP_MTHI  = 4'b0111;
  localparam logic [3:0] OP_MTLO  = 4'b1000;

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic [1:0] {K_MULT, K_MULTU, K_DIV, K_DIVU} kind_t;

  state_t             state_q;
  kind_t              kind_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic               busy_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;

  logic               is_md;
  kind_t              kind_dec;
  logic [CNT_W-1:0]   lat_dec;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        abs_a;
  logic [31:0]        abs_b;
  logic [31:0]        uq;
  logic [31:0]        ur;
  logic [31:0]        hi_res;
  logic [31:0]        lo_res;
  logic               res_wr;

  // Decode an md-class opcode into its kind and latency.
  always_comb begin
    is_md    = 1'b1;
    kind_dec = K_MULT;
    lat_dec  = CNT_W'(MULT_CYCLES);
    case (MDUOp)
      OP_MULT:  kind_dec = K_MULT;
      OP_MULTU: kind_dec = K_MULTU;
      OP_DIV:   begin kind_dec = K_DIV;  lat_dec = CNT_W'(DIV_CYCLES); end
      OP_DIVU:  begin kind_dec = K_DIVU; lat_dec = CNT_W'(DIV_CYCLES); end
      default:  is_md = 1'b0;
    endcase
  end

  // Signed divide via magnitudes so 0x80000000 / -1 needs no special case.
  always_comb begin
    prod_s = $signed(64'($signed(a_q))) * $signed(64'($signed(b_q)));
    prod_u = 64'(a_q) * 64'(b_q);
    abs_a  = (kind_q == K_DIV && a_q[31]) ? -a_q : a_q;
    abs_b  = (kind_q == K_DIV && b_q[31]) ? -b_q : b_q;
    uq     = (abs_b != 32'd0) ? abs_a / abs_b : 32'd0;
    ur     = (abs_b != 32'd0) ? abs_a % abs_b : 32'd0;
    hi_res = 32'd0;
    lo_res = 32'd0;
    res_wr = 1'b1;
    case (kind_q)
      K_MULT:  begin hi_res = prod_s[63:32]; lo_res = prod_s[31:0]; end
      K_MULTU: begin hi_res = prod_u[63:32]; lo_res = prod_u[31:0]; end
      K_DIV: begin
        lo_res = (a_q[31] ^ b_q[31]) ? -uq : uq;
        hi_res = a_q[31] ? -ur : ur;
        res_wr = (b_q != 32'd0);
      end
      default: begin
        lo_res = uq;
        hi_res = ur;
        res_wr = (b_q != 32'd0);
      end
    endcase
  end

  // Control FSM with registered busy and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_MULT;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && is_md) begin
            a_q     <= MDU_A;
            b_q     <= MDU_B;
            kind_q  <= kind_dec;
            cnt_q   <= lat_dec;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else if (MDUOp == OP_MTHI) begin
            hi_q <= MDU_A;
          end else if (MDUOp == OP_MTLO) begin
            lo_q <= MDU_A;
          end
        end
        default: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
            if (res_wr) begin
              hi_q <= hi_res;
              lo_q <= lo_res;
            end
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;
  assign out  = (MDUOp == OP_MFHI) ? hi_q :
                (MDUOp == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: a reference model pushes expected HI/LO and
// latency to a scoreboard at issue; entries are popped when busy drops.
module tb_e_mdu;

  localparam logic [3:0] OP_NONE  = 4'b0000;
  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MFHI  = 4'b0101;
  localparam logic [3:0] OP_MFLO  = 4'b0110;
  localparam logic [3:0] OP_MTHI  = 4'b0111;
  localparam logic [3:0] OP_MTLO  = 4'b1000;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] MDU_A;
  logic [31:0] MDU_B;
  logic [3:0]  MDUOp;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] out;

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        sb[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDU_A(MDU_A), .MDU_B(MDU_B), .MDUOp(MDUOp),
    .start(start), .busy(busy), .HI(HI), .LO(LO), .out(out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: 64-bit signed arithmetic, truncating division.
  task automatic push_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sbv, p, q, r;
    logic [63:0] pu;
    e.lat = (op == OP_MULT || op == OP_MULTU) ? 5 : 10;
    case (op)
      OP_MULT: begin
        sa = longint'($signed(a)); sbv = longint'($signed(b)); p = sa * sbv;
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      OP_MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        m_hi = pu[63:32]; m_lo = pu[31:0];
      end
      OP_DIV: if (b != 32'd0) begin
        sa = longint'($signed(a)); sbv = longint'($signed(b));
        q = sa / sbv; r = sa % sbv;
        m_hi = r[31:0]; m_lo = q[31:0];
      end
      default: if (b != 32'd0) begin
        m_hi = a % b; m_lo = a / b;
      end
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
    sb.push_back(e);
  endtask

  // Drive one md-class op for one edge, then scramble operands.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    MDUOp = op; start = 1'b1; MDU_A = a; MDU_B = b;
    push_exp(op, a, b);
    tick();
    MDUOp = OP_NONE; start = 1'b0; MDU_A = $urandom; MDU_B = $urandom;
  endtask

  // Count busy samples (bounded), then compare against the scoreboard head.
  task automatic wait_done(input string tag, input int seen);
    int   cnt;
    exp_t e;
    cnt = seen;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_lat"}, 32'(cnt), 32'(e.lat));
      chk({tag, "_hi"}, HI, e.hi);
      chk({tag, "_lo"}, LO, e.lo);
    end
  endtask

  initial begin
    reset = 1'b1; MDU_A = '0; MDU_B = '0; MDUOp = OP_NONE; start = 1'b0;
    m_hi = '0; m_lo = '0;

    // Reset and read-out
    tick(); tick();
    reset = 1'b0;
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    MDUOp = OP_MFHI; #1 chk("rst_mfhi", out, 32'd0);
    MDUOp = OP_MFLO; #1 chk("rst_mflo", out, 32'd0);
    MDUOp = OP_NONE;

    // md opcode without start is ignored
    MDUOp = OP_MULT; MDU_A = 32'd9; MDU_B = 32'd9;
    tick();
    chk("nostart_busy", 32'(busy), 32'd0);
    MDUOp = OP_NONE;

    // mult / multu latency and results
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    chk("mult_busy1", 32'(busy), 32'd1);
    wait_done("mult", 0);
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_done("multu", 0);

    // div signs, overflow, divide by zero
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 0);
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done("div_negb", 0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 0);
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd7);
    wait_done("divu", 0);
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_done("divu_zero", 0);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done("div_zero", 0);

    // Busy protection: divu at busy cycle 2, mthi at busy cycle 3
    issue(OP_MULT, 32'h0001_2345, 32'hFFFF_0F0F);
    tick();
    MDUOp = OP_DIVU; start = 1'b1; MDU_A = 32'd100; MDU_B = 32'd3;
    tick();
    MDUOp = OP_MTHI; start = 1'b0; MDU_A = 32'h0000_1234;
    tick();
    MDUOp = OP_NONE;
    chk("prot_busy4", 32'(busy), 32'd1);
    wait_done("prot", 3);

    // mthi / mtlo then read-out
    MDUOp = OP_MTHI; MDU_A = 32'hDEAD_BEEF;
    tick();
    MDUOp = OP_MTLO; MDU_A = 32'h0BAD_F00D;
    chk("mthi_busy", 32'(busy), 32'd0);
    tick();
    chk("mtlo_busy", 32'(busy), 32'd0);
    MDUOp = OP_MFHI; #1 chk("mfhi_out", out, 32'hDEAD_BEEF);
    MDUOp = OP_MFLO; #1 chk("mflo_out", out, 32'h0BAD_F00D);
    MDUOp = OP_NONE; #1 chk("none_out", out, 32'd0);
    chk("mt_hi", HI, 32'hDEAD_BEEF);
    m_hi = 32'hDEAD_BEEF; m_lo = 32'h0BAD_F00D;

    // mfhi during busy returns stale HI
    issue(OP_MULTU, 32'd4, 32'd5);
    MDUOp = OP_MFHI; #1 chk("mfhi_stale", out, 32'hDEAD_BEEF);
    MDUOp = OP_NONE;
    wait_done("multu_small", 0);

    // Reset mid-operation abandons the divide
    issue(OP_DIVU, 32'd1000, 32'd7);
    void'(sb.pop_back());
    tick(); tick(); tick();
    chk("mid_busy4", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_hi", HI, 32'd0);
    chk("mid_rst_lo", LO, 32'd0);
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_done("post_rst_mult", 0);
    repeat (8) tick();
    chk("post_quiet_busy", 32'(busy), 32'd0);
    chk("post_quiet_lo", LO, 32'd0);
    chk("post_quiet_hi", HI, 32'h4000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
